// File: rtl/msg_rx_if.sv
// Handshake bundle for msg_rx: descriptor in, payload beats in, cells out, packet info out.
// slave is the msg_rx side, master is the upstream/downstream environment side.
interface msg_rx_if #(
    parameter int DWID    = 256,
    parameter int MSG_WID = 32,
    parameter int PDWID   = 64,
    parameter int PIMWID  = 64
);
    logic               pd_vld;
    logic               pd_rdy;
    logic [PDWID-1:0]   pd_dat;

    logic               in_dat_vld;
    logic               in_dat_rdy;
    logic [DWID-1:0]    in_dat_dat;
    logic               in_dat_eop;

    logic               out_cell_vld;
    logic               out_cell_rdy;
    logic [DWID-1:0]    out_cell_dat;
    logic [MSG_WID-1:0] out_cell_msg;

    logic               pkt_info_vld;
    logic               pkt_info_rdy;
    logic [PIMWID-1:0]  pkt_info_msg;

    modport slave (
        input  pd_vld, pd_dat, in_dat_vld, in_dat_dat, in_dat_eop, out_cell_rdy, pkt_info_rdy,
        output pd_rdy, in_dat_rdy, out_cell_vld, out_cell_dat, out_cell_msg, pkt_info_vld, pkt_info_msg
    );

    modport master (
        output pd_vld, pd_dat, in_dat_vld, in_dat_dat, in_dat_eop, out_cell_rdy, pkt_info_rdy,
        input  pd_rdy, in_dat_rdy, out_cell_vld, out_cell_dat, out_cell_msg, pkt_info_vld, pkt_info_msg
    );
endinterface

// File: rtl/msg_rx.sv
// Packet receiver: takes a descriptor, slices the payload into 32-byte cells, then emits a summary.
// Optional length/eop cross-check enabled by defining MSG_RX_LEN_CHK_EN.
module msg_rx #(
    parameter int DWID    = 256,
    parameter int MSG_WID = 32,
    parameter int PDWID   = 64,
    parameter int PIMWID  = 64
) (
    input  logic        clk,
    input  logic        rst,
    msg_rx_if.slave     bus,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, CELL, DRAIN, INFO} state_t;

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [3:0]           chn_q, chn_d;
    logic [11:0]          left_q, left_d;
    logic [11:0]          idx_q, idx_d;
    logic                 err_q, err_d;
    logic                 ov_q, ov_d;
    logic [DWID-1:0]      odat_q, odat_d;
    logic [MSG_WID-1:0]   omsg_q, omsg_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic                 init_q, init_d;

    logic                 blk;
    logic                 pd_rdy, in_rdy, oc_vld, info_vld;
    logic                 pd_fire, in_fire, oc_fire, info_fire;
    logic [16:0]          ceil_w;
    logic                 last, cell_eop, cell_err, early, bad;
    logic [5:0]           vbytes;

    logic                 unused_pd;
    assign unused_pd = ^bus.pd_dat[PDWID-1:20];

    // Outputs stay quiet during reset and for one cycle after its release.
    assign blk      = rst | init_q;
    assign pd_rdy   = ~blk & (state_q == IDLE);
    assign in_rdy   = ~blk & (((state_q == CELL) & (~ov_q | bus.out_cell_rdy)) | (state_q == DRAIN));
    assign oc_vld   = ~blk & ov_q;
    assign info_vld = ~blk & (state_q == INFO) & ~ov_q;

    assign pd_fire   = bus.pd_vld & pd_rdy;
    assign in_fire   = bus.in_dat_vld & in_rdy;
    assign oc_fire   = oc_vld & bus.out_cell_rdy;
    assign info_fire = info_vld & bus.pkt_info_rdy;

    assign ceil_w = {1'b0, bus.pd_dat[15:0]} + 17'd31;
    assign last   = (left_q == 12'd1);
    assign vbytes = (last && (len_q[4:0] != 5'd0)) ? {1'b0, len_q[4:0]} : 6'd32;

`ifdef MSG_RX_LEN_CHK_EN
    assign early = bus.in_dat_eop & ~last;
    assign bad   = last & ~bus.in_dat_eop;
`else
    assign early = 1'b0;
    assign bad   = 1'b0;
`endif
    assign cell_eop = last | early;
    assign cell_err = err_q | early | bad;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chn_d     = chn_q;
        left_d    = left_q;
        idx_d     = idx_q;
        err_d     = err_q;
        ov_d      = ov_q;
        odat_d    = odat_q;
        omsg_d    = omsg_q;
        err_cnt_d = err_cnt_q;
        init_d    = 1'b0;

        if (oc_fire) ov_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pd_fire) begin
                    len_d  = bus.pd_dat[15:0];
                    chn_d  = bus.pd_dat[19:16];
                    left_d = ceil_w[16:5];
                    idx_d  = 12'd0;
                    err_d  = (bus.pd_dat[15:0] == 16'd0);
                    state_d = (bus.pd_dat[15:0] == 16'd0) ? INFO : CELL;
                end
            end
            CELL: begin
                if (in_fire) begin
                    ov_d   = 1'b1;
                    odat_d = bus.in_dat_dat;
                    omsg_d = MSG_WID'({7'd0, cell_err, idx_q, chn_q, vbytes, cell_eop, idx_q == 12'd0});
                    idx_d  = idx_q + 12'd1;
                    left_d = left_q - 12'd1;
                    err_d  = cell_err;
                    if (bad)           state_d = DRAIN;
                    else if (cell_eop) state_d = INFO;
                end
            end
            DRAIN: begin
                if (in_fire && bus.in_dat_eop) state_d = INFO;
            end
            INFO: begin
                if (info_fire) begin
                    state_d = IDLE;
                    if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            chn_q     <= '0;
            left_q    <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
            odat_q    <= '0;
            omsg_q    <= '0;
            err_cnt_q <= '0;
            init_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            chn_q     <= chn_d;
            left_q    <= left_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
            odat_q    <= odat_d;
            omsg_q    <= omsg_d;
            err_cnt_q <= err_cnt_d;
            init_q    <= init_d;
        end
    end

    assign bus.pd_rdy       = pd_rdy;
    assign bus.in_dat_rdy   = in_rdy;
    assign bus.out_cell_vld = oc_vld;
    assign bus.out_cell_dat = odat_q;
    assign bus.out_cell_msg = omsg_q;
    assign bus.pkt_info_vld = info_vld;
    assign bus.pkt_info_msg = PIMWID'({31'd0, err_q, idx_q, chn_q, len_q});
    assign err_cnt          = rst ? 16'd0 : err_cnt_q;

endmodule

// File: tb/tb_msg_rx.sv
// Randomized bench for msg_rx: a packet-level model predicts cells and info, a monitor scoreboards them.
module tb_msg_rx;
    localparam int DWID = 256;
`ifdef MSG_RX_LEN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct { logic [DWID-1:0] dat; logic eop; } beat_t;
    typedef struct { logic [31:0] msg; logic [DWID-1:0] dat; } cell_t;

    logic        clk, rst;
    logic [15:0] err_cnt;
    int          n_chk = 0, n_fail = 0;
    int          rmode = 2;
    int          n_cells = 0;
    logic [31:0] last_cell_msg = '0;
    logic [15:0] exp_err_cnt = '0;

    beat_t       beat_q[$];
    cell_t       exp_cells[$];
    logic [63:0] exp_info[$];
    cell_t       m_cells[$];
    logic [63:0] m_info;
    int          m_used;

    msg_rx_if #(.DWID(DWID), .MSG_WID(32), .PDWID(64), .PIMWID(64)) b ();
    msg_rx #(.DWID(DWID), .MSG_WID(32), .PDWID(64), .PIMWID(64)) dut (
        .clk(clk), .rst(rst), .bus(b.slave), .err_cnt(err_cnt)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    task automatic chk(input string name, input logic [DWID-1:0] act, input logic [DWID-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DWID-1:0] rnd_dat();
        logic [DWID-1:0] d;
        for (int k = 0; k < DWID/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Packet-level prediction: which beats are consumed, which cells come out, what the summary says.
    task automatic model(input int len, input int chn, input beat_t bq[$]);
        int n, i;
        logic err, last, early, bad;
        logic [5:0] vb;
        cell_t c;
        m_cells.delete();
        n = (len + 31) / 32;
        err = (len == 0);
        i = 0;
        for (int ci = 0; ci < n; ci++) begin
            last  = (ci == n - 1);
            early = CHK && bq[i].eop && !last;
            bad   = CHK && last && !bq[i].eop;
            if (early || bad) err = 1'b1;
            vb = (last && (len % 32 != 0)) ? 6'(len % 32) : 6'd32;
            c.msg = {7'd0, err, 12'(ci), 4'(chn), vb, last | early, ci == 0};
            c.dat = bq[i].dat;
            m_cells.push_back(c);
            i++;
            if (bad) begin
                while (!bq[i].eop) i++;
                i++;
            end
            if (early) break;
        end
        m_used = i;
        m_info = {31'd0, err, 12'(m_cells.size()), 4'(chn), 16'(len)};
    endtask

    task automatic mk_beats(input int nb, input int e, output beat_t bq[$]);
        beat_t bt;
        bq.delete();
        for (int k = 0; k < nb; k++) begin
            bt.dat = rnd_dat();
            bt.eop = (k == e);
            bq.push_back(bt);
        end
    endtask

    task automatic drive_pd(input int len, input int chn);
        bit done = 1'b0;
        @(posedge clk); #1;
        b.pd_vld = 1'b1;
        b.pd_dat = {$urandom, $urandom};
        b.pd_dat[15:0]  = 16'(len);
        b.pd_dat[19:16] = 4'(chn);
        for (int k = 0; k < 20000 && !done; k++) begin
            @(negedge clk);
            if (b.pd_rdy) done = 1'b1;
            @(posedge clk); #1;
        end
        b.pd_vld = 1'b0;
        chk("pd_accept_timeout", done, 1);
    endtask

    task automatic send(input int len, input int chn, input beat_t bq[$]);
        model(len, chn, bq);
        foreach (m_cells[k]) exp_cells.push_back(m_cells[k]);
        exp_info.push_back(m_info);
        for (int k = 0; k < m_used; k++) beat_q.push_back(bq[k]);
        drive_pd(len, chn);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 30000 && !done; k++) begin
            @(negedge clk);
            if (exp_cells.size() == 0 && exp_info.size() == 0 && beat_q.size() == 0 && b.pd_rdy) done = 1'b1;
        end
        chk("idle_timeout", done, 1);
    endtask

    // Payload beat driver: random gaps, payload held until accepted.
    initial begin : bdrv
        logic fire;
        b.in_dat_vld = 1'b0; b.in_dat_dat = '0; b.in_dat_eop = 1'b0;
        forever begin
            @(negedge clk);
            fire = b.in_dat_vld && b.in_dat_rdy;
            @(posedge clk); #1;
            if (rst) begin
                beat_q.delete();
                b.in_dat_vld = 1'b0;
            end else begin
                if (fire) begin
                    void'(beat_q.pop_front());
                    b.in_dat_vld = 1'b0;
                end
                if (!b.in_dat_vld && beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    b.in_dat_vld = 1'b1;
                    b.in_dat_dat = beat_q[0].dat;
                    b.in_dat_eop = beat_q[0].eop;
                end
            end
        end
    end

    initial begin : rdrv
        b.out_cell_rdy = 1'b1; b.pkt_info_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: begin b.out_cell_rdy = 1'($urandom_range(0, 1)); b.pkt_info_rdy = 1'($urandom_range(0, 1)); end
                1: begin b.out_cell_rdy = ~b.out_cell_rdy; b.pkt_info_rdy = 1'b1; end
                default: begin b.out_cell_rdy = 1'b1; b.pkt_info_rdy = 1'b1; end
            endcase
        end
    end

    initial begin : mon
        logic pv_c, pv_i, pend;
        logic [31:0] pm;
        logic [DWID-1:0] pdt;
        logic [63:0] pim;
        cell_t c;
        logic [63:0] ei;
        pv_c = 1'b0; pv_i = 1'b0; pend = 1'b0; pm = '0; pdt = '0; pim = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_cells.delete(); exp_info.delete();
                exp_err_cnt = '0; pend = 1'b0; pv_c = 1'b0; pv_i = 1'b0;
            end else begin
                if (pend) begin
                    if (exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
                    pend = 1'b0;
                end
                chk("err_cnt", err_cnt, exp_err_cnt);
                chk("info_with_cell_held", b.pkt_info_vld & b.out_cell_vld, 0);
                if (pv_c) begin
                    chk("cell_hold_vld", b.out_cell_vld, 1);
                    chk("cell_hold_msg", b.out_cell_msg, pm);
                    chk("cell_hold_dat", b.out_cell_dat, pdt);
                end
                if (pv_i) begin
                    chk("info_hold_vld", b.pkt_info_vld, 1);
                    chk("info_hold_msg", b.pkt_info_msg, pim);
                end
                if (b.out_cell_vld && b.out_cell_rdy) begin
                    chk("cell_expected", exp_cells.size() != 0, 1);
                    if (exp_cells.size() != 0) begin
                        c = exp_cells.pop_front();
                        chk("cell_msg", b.out_cell_msg, c.msg);
                        chk("cell_dat", b.out_cell_dat, c.dat);
                    end
                    last_cell_msg = b.out_cell_msg;
                    n_cells++;
                end
                if (b.pkt_info_vld && b.pkt_info_rdy) begin
                    chk("info_expected", exp_info.size() != 0, 1);
                    if (exp_info.size() != 0) begin
                        ei = exp_info.pop_front();
                        chk("info_msg", b.pkt_info_msg, ei);
                        pend = ei[32];
                    end
                end
                pv_c = b.out_cell_vld & ~b.out_cell_rdy; pm = b.out_cell_msg; pdt = b.out_cell_dat;
                pv_i = b.pkt_info_vld & ~b.pkt_info_rdy; pim = b.pkt_info_msg;
            end
        end
    end

    initial begin : main
        beat_t bq[$];
        int len, n, nb, e, base;
        bit done;
        rst = 1'b1; b.pd_vld = 1'b0; b.pd_dat = '0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_hs_outs", {b.pd_rdy, b.in_dat_rdy, b.out_cell_vld, b.pkt_info_vld}, 0);
            chk("rst_err_cnt", err_cnt, 0);
        end
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); chk("rel1_hs_outs", {b.pd_rdy, b.in_dat_rdy, b.out_cell_vld, b.pkt_info_vld}, 0);
        @(negedge clk); chk("rel2_pd_rdy", b.pd_rdy, 1);

        // Pin the model with hand-computed values: len=100 chn=3, 4 beats.
        mk_beats(4, 3, bq);
        model(100, 3, bq);
        chk("pin_ncells", m_cells.size(), 4);
        chk("pin_msg0", m_cells[0].msg, 32'h0000_0381);
        chk("pin_msg1", m_cells[1].msg, 32'h0000_1380);
        chk("pin_msg2", m_cells[2].msg, 32'h0000_2380);
        chk("pin_msg3", m_cells[3].msg, 32'h0000_3312);
        chk("pin_info", m_info, 64'h0000_0000_0043_0064);
        rmode = 2;
        send(100, 3, bq);
        wait_idle();
        chk("p100_last_msg", last_cell_msg, 32'h0000_3312);

        // Zero-length packet: no beats, error counted.
        bq.delete();
        model(0, 2, bq);
        chk("pin_len0_info", m_info, 64'h0000_0001_0002_0000);
        send(0, 2, bq);
        wait_idle();
        chk("len0_err_cnt", err_cnt, 16'd1);

        // Back-pressure toggling: exactly two cells.
        rmode = 1;
        base = n_cells;
        mk_beats(2, 1, bq);
        send(64, 6, bq);
        wait_idle();
        chk("toggle_ncells", n_cells - base, 2);

        // Early eop on beat 2 of a 3-cell packet.
        rmode = 2;
        mk_beats(3, 1, bq);
        model(96, 1, bq);
        chk("early_ncells", m_cells.size(), CHK ? 2 : 3);
        chk("early_info_err", m_info[32], CHK);
        send(96, 1, bq);
        wait_idle();

        // Missing eop on the last cell: eop on beat 3 of a 1-cell packet.
        mk_beats(3, 2, bq);
        model(32, 4, bq);
        chk("late_used", m_used, CHK ? 3 : 1);
        chk("late_cell_err", m_cells[0].msg[24], CHK);
        send(32, 4, bq);
        wait_idle();

        // Random traffic.
        for (int p = 0; p < 40; p++) begin
            rmode = (p < 20) ? 0 : int'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = 32 * int'($urandom_range(1, 8));
                default: len = int'($urandom_range(1, 300));
            endcase
            n  = (len + 31) / 32;
            nb = (n == 0) ? 0 : n + int'($urandom_range(0, 3));
            e  = (n == 0) ? -1 : (($urandom_range(0, 9) < 6) ? n - 1 : int'($urandom_range(0, nb - 1)));
            mk_beats(nb, e, bq);
            send(len, int'($urandom_range(0, 15)), bq);
        end
        wait_idle();

        // Maximum length: cell index reaches 2047 without wrapping.
        rmode = 2;
        mk_beats(2048, 2047, bq);
        model(65535, 15, bq);
        chk("max_info", m_info, 64'h0000_0000_800F_FFFF);
        send(65535, 15, bq);
        wait_idle();
        chk("max_last_msg", last_cell_msg, 32'h007F_FF7E);

        // Reset mid-packet after the first cell.
        base = n_cells;
        mk_beats(4, 3, bq);
        send(128, 5, bq);
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (n_cells > base) done = 1'b1;
        end
        chk("mid_cell_timeout", done, 1);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("mrst_hs_outs", {b.pd_rdy, b.in_dat_rdy, b.out_cell_vld, b.pkt_info_vld}, 0);
        chk("mrst_err_cnt", err_cnt, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); chk("mrel1_hs_outs", {b.pd_rdy, b.in_dat_rdy, b.out_cell_vld, b.pkt_info_vld}, 0);
        @(negedge clk); chk("mrel2_pd_rdy", b.pd_rdy, 1);
        chk("mrel2_err_cnt", err_cnt, 0);
        repeat (5) @(negedge clk);
        base = n_cells;
        mk_beats(1, 0, bq);
        send(32, 7, bq);
        wait_idle();
        chk("post_rst_ncells", n_cells - base, 1);
        chk("post_rst_msg", last_cell_msg, 32'h0000_0783);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
